// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing generator with registered DAC outputs
// Optional feature macro: VGA_TEST_PATTERN_EN (built-in test patterns selected by pat_sel_i)
module vga_timing_gen #(
    parameter int HD     = 1280,
    parameter int HF     = 48,
    parameter int HR     = 112,
    parameter int HB     = 248,
    parameter int VD     = 1024,
    parameter int VF     = 1,
    parameter int VR     = 3,
    parameter int VB     = 38,
    parameter bit HS_POL = 1'b1,
    parameter bit VS_POL = 1'b1,
    parameter int CW     = 4,
    parameter int HW     = 11,
    parameter int VW     = 11
) (
    input  logic            clk,
    input  logic            arstn,
    input  logic            ce,
    input  logic [3*CW-1:0] pix_rgb_i,
    input  logic [1:0]      pat_sel_i,
    output logic            VGA_HS,
    output logic            VGA_VS,
    output logic [3*CW-1:0] RGB,
    output logic            pixel_enable,
    output logic [HW-1:0]   hcount,
    output logic [VW-1:0]   vcount,
    output logic            line_start,
    output logic            frame_start
);

    // Region boundaries at counter width so every compare is unsigned and width-matched
    localparam logic [HW-1:0] H_MAX      = HW'(HD + HF + HR + HB - 1);
    localparam logic [HW-1:0] H_DE_END   = HW'(HD);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(HD + HF);
    localparam logic [HW-1:0] H_SYNC_END = HW'(HD + HF + HR);
    localparam logic [VW-1:0] V_MAX      = VW'(VD + VF + VR + VB - 1);
    localparam logic [VW-1:0] V_DE_END   = VW'(VD);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(VD + VF);
    localparam logic [VW-1:0] V_SYNC_END = VW'(VD + VF + VR);

    logic            de;
    logic            hs_next;
    logic            vs_next;
    logic            ls_next;
    logic            fs_next;
    logic [3*CW-1:0] pixel;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0]    bar_idx;
    logic [CW-1:0] ramp;

    // Pixel source mux: pass-through or one of the generated patterns
    always_comb begin
        bar_idx = 3'((32'(hcount) * 32'd8) / 32'(HD));
        ramp    = CW'(hcount >> 4);
        pixel   = pix_rgb_i;
        case (pat_sel_i)
            2'd0: pixel = pix_rgb_i;
            2'd1: pixel = {{CW{bar_idx[2]}}, {CW{bar_idx[1]}}, {CW{bar_idx[0]}}};
            2'd2: pixel = (1'(hcount >> 5) ^ 1'(vcount >> 5)) ? {3*CW{1'b1}} : {3*CW{1'b0}};
            default: pixel = {ramp, ramp, ramp};
        endcase
    end
`else
    logic unused_pat_sel;

    // Without patterns the caller's pixel goes straight to the output register
    always_comb begin
        pixel          = pix_rgb_i;
        unused_pat_sel = ^pat_sel_i;
    end
`endif

    // Decode sync, enable and strobes from the current counter position
    always_comb begin
        de      = (hcount < H_DE_END) && (vcount < V_DE_END);
        hs_next = ((hcount >= H_SYNC_BEG) && (hcount < H_SYNC_END)) ? HS_POL : ~HS_POL;
        vs_next = ((vcount >= V_SYNC_BEG) && (vcount < V_SYNC_END)) ? VS_POL : ~VS_POL;
        ls_next = (hcount == '0) && (vcount < V_DE_END);
        fs_next = (hcount == '0) && (vcount == '0);
    end

    // Horizontal/vertical position counters, advancing only on clock-enable
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            hcount <= '0;
            vcount <= '0;
        end else if (ce) begin
            if (hcount == H_MAX) begin
                hcount <= '0;
                vcount <= (vcount == V_MAX) ? '0 : vcount + 1'b1;
            end else begin
                hcount <= hcount + 1'b1;
            end
        end
    end

    // Pin registers: all outputs launch together, one ce-cycle behind the counters
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            VGA_HS       <= ~HS_POL;
            VGA_VS       <= ~VS_POL;
            RGB          <= '0;
            pixel_enable <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else if (ce) begin
            VGA_HS       <= hs_next;
            VGA_VS       <= vs_next;
            RGB          <= de ? pixel : '0;
            pixel_enable <= de;
            line_start   <= ls_next;
            frame_start  <= fs_next;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    localparam int HD = 8, HF = 2, HR = 3, HB = 3;
    localparam int VD = 4, VF = 1, VR = 2, VB = 1;
    localparam int CW = 4, HW = 8, VW = 6;
    localparam int HTOT = HD + HF + HR + HB;
    localparam int VTOT = VD + VF + VR + VB;
    localparam int FTOT = HTOT * VTOT;

    logic            clk = 1'b0;
    logic            arstn;
    logic            ce;
    logic [3*CW-1:0] pix_rgb_i;
    logic [1:0]      pat_sel_i;
    logic            VGA_HS, VGA_VS, pixel_enable, line_start, frame_start;
    logic [3*CW-1:0] RGB;
    logic [HW-1:0]   hcount;
    logic [VW-1:0]   vcount;

    int total = 0;
    int bad   = 0;
    int n     = 0;
    logic [11:0] last_rgb = 12'h0;
    logic [1:0]  last_sel = 2'd0;

    localparam logic [30:0] RESET_VEC = {1'b1, 1'b1, 12'h0, 1'b0, 8'd0, 6'd0, 1'b0, 1'b0};

    wire [30:0] obs = {VGA_HS, VGA_VS, RGB, pixel_enable, hcount, vcount, line_start, frame_start};

    vga_timing_gen #(
        .HD(HD), .HF(HF), .HR(HR), .HB(HB),
        .VD(VD), .VF(VF), .VR(VR), .VB(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW), .HW(HW), .VW(VW)
    ) dut (
        .clk(clk), .arstn(arstn), .ce(ce), .pix_rgb_i(pix_rgb_i), .pat_sel_i(pat_sel_i),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .RGB(RGB), .pixel_enable(pixel_enable),
        .hcount(hcount), .vcount(vcount), .line_start(line_start), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Pixel the design should show for position (h,v)
    function automatic logic [11:0] pixel_model(int h, int v);
`ifdef VGA_TEST_PATTERN_EN
        int bar;
        logic [3:0] r;
        case (last_sel)
            2'd0: return last_rgb;
            2'd1: begin
                bar = (h * 8) / HD;
                return {((bar / 4) % 2) ? 4'hF : 4'h0, ((bar / 2) % 2) ? 4'hF : 4'h0, (bar % 2) ? 4'hF : 4'h0};
            end
            2'd2: return (((h / 32) % 2) != ((v / 32) % 2)) ? 12'hFFF : 12'h000;
            default: begin
                r = 4'((h / 16) % 16);
                return {r, r, r};
            end
        endcase
`else
        if (h < 0 || v < 0) return 12'h0;
        return last_rgb;
`endif
    endfunction

    // Expected pin state after cnt enabled clocks since reset
    function automatic logic [30:0] exp_vec(int cnt);
        int p, hp, vp, hc, vc;
        logic de, hs, vs, ls, fs;
        if (cnt == 0) return RESET_VEC;
        hc = cnt % HTOT;
        vc = (cnt / HTOT) % VTOT;
        p  = cnt - 1;
        hp = p % HTOT;
        vp = (p / HTOT) % VTOT;
        de = (hp < HD) && (vp < VD);
        hs = !((hp >= HD + HF) && (hp < HD + HF + HR));
        vs = !((vp >= VD + VF) && (vp < VD + VF + VR));
        ls = (hp == 0) && (vp < VD);
        fs = (hp == 0) && (vp == 0);
        return {hs, vs, de ? pixel_model(hp, vp) : 12'h0, de, 8'(hc), 6'(vc), ls, fs};
    endfunction

    task automatic step(input logic c, input logic [11:0] rgb, input logic [1:0] sel);
        ce        = c;
        pix_rgb_i = rgb;
        pat_sel_i = sel;
        @(posedge clk);
        #1;
        if (c) begin
            n++;
            last_rgb = rgb;
            last_sel = sel;
        end
    endtask

    task automatic test_reset();
        int fs_cnt;
        arstn = 1'b0; ce = 1'b1; pix_rgb_i = 12'hFFF; pat_sel_i = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (obs !== RESET_VEC) begin bad++; $display("FAIL reset_values got=%h exp=%h", obs, RESET_VEC); end
        @(negedge clk);
        arstn = 1'b1;
        n = 0;
        step(1'b1, 12'h123, 2'd0);
        total++;
        if (frame_start !== 1'b1 || hcount !== 8'd1) begin
            bad++; $display("FAIL first_frame_start got fs=%b h=%0d exp fs=1 h=1", frame_start, hcount);
        end
        fs_cnt = 0;
        for (int i = 0; i < FTOT; i++) begin
            step(1'b1, 12'(($urandom)), 2'd0);
            if (frame_start === 1'b1) fs_cnt++;
        end
        total++;
        if (frame_start !== 1'b1 || fs_cnt !== 1) begin
            bad++; $display("FAIL frame_period got fs=%b count=%0d exp fs=1 count=1", frame_start, fs_cnt);
        end
    endtask

    task automatic test_free_run();
        int hs_low, vs_low, pe_cnt, ls_cnt;
        hs_low = 0; vs_low = 0; pe_cnt = 0; ls_cnt = 0;
        for (int i = 0; i < FTOT; i++) begin
            step(1'b1, 12'($urandom), 2'd0);
            total++;
            if (obs !== exp_vec(n)) begin
                bad++;
                if (bad < 30) $display("FAIL free_run n=%0d got=%h exp=%h", n, obs, exp_vec(n));
            end
            if (VGA_HS === 1'b0) hs_low++;
            if (VGA_VS === 1'b0) vs_low++;
            if (pixel_enable === 1'b1) pe_cnt++;
            if (line_start === 1'b1) ls_cnt++;
        end
        total++;
        if (hs_low !== 3 * VTOT || vs_low !== VR * HTOT || pe_cnt !== HD * VD || ls_cnt !== VD) begin
            bad++;
            $display("FAIL frame_counts got hs=%0d vs=%0d pe=%0d ls=%0d exp hs=%0d vs=%0d pe=%0d ls=%0d",
                     hs_low, vs_low, pe_cnt, ls_cnt, 3 * VTOT, VR * HTOT, HD * VD, VD);
        end
    endtask

    task automatic test_const_rgb();
        int good_px, leak;
        good_px = 0; leak = 0;
        for (int i = 0; i < FTOT; i++) begin
            step(1'b1, 12'hA5C, 2'd0);
            total++;
            if (obs !== exp_vec(n)) begin
                bad++;
                if (bad < 30) $display("FAIL const_rgb n=%0d got=%h exp=%h", n, obs, exp_vec(n));
            end
            if (pixel_enable === 1'b1 && RGB === 12'hA5C) good_px++;
            if (pixel_enable !== 1'b1 && RGB !== 12'h000) leak++;
        end
        total++;
        if (good_px !== HD * VD || leak !== 0) begin
            bad++; $display("FAIL const_rgb_count got good=%0d leak=%0d exp good=%0d leak=0", good_px, leak, HD * VD);
        end
    endtask

    task automatic test_ce_gating();
        logic c;
        logic [3:0] seq;
        seq = 4'b1001;
        for (int i = 3; i >= 0; i--) begin
            step(seq[i], 12'($urandom), 2'd0);
            total++;
            if (obs !== exp_vec(n)) begin bad++; $display("FAIL ce_seq i=%0d got=%h exp=%h", i, obs, exp_vec(n)); end
        end
        for (int i = 0; i < 300; i++) begin
            c = 1'($urandom);
            step(c, 12'($urandom), 2'd0);
            total++;
            if (obs !== exp_vec(n)) begin
                bad++;
                if (bad < 30) $display("FAIL ce_random n=%0d got=%h exp=%h", n, obs, exp_vec(n));
            end
        end
    endtask

    task automatic test_async_reset();
        int guard;
        guard = 0;
        while ((n % FTOT) != 2 * HTOT + 9 && guard < 2 * FTOT) begin
            step(1'b1, 12'($urandom), 2'd0);
            guard++;
        end
        total++;
        if (hcount !== 8'd9 || vcount !== 6'd2) begin
            bad++; $display("FAIL async_pos got h=%0d v=%0d exp h=9 v=2", hcount, vcount);
        end
        #2;
        arstn = 1'b0;
        #1;
        total++;
        if (obs !== RESET_VEC) begin bad++; $display("FAIL async_reset got=%h exp=%h", obs, RESET_VEC); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        arstn = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 12'($urandom), 2'd0);
            total++;
            if (obs !== exp_vec(n)) begin bad++; $display("FAIL async_resume n=%0d got=%h exp=%h", n, obs, exp_vec(n)); end
        end
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern();
        logic [11:0] bars [8];
        int guard;
        bars = '{12'h000, 12'h00F, 12'h0F0, 12'h0FF, 12'hF00, 12'hF0F, 12'hFF0, 12'hFFF};
        guard = 0;
        while ((n % FTOT) != 0 && guard < 2 * FTOT) begin
            step(1'b1, 12'h5A5, 2'd1);
            guard++;
        end
        for (int k = 0; k < HTOT; k++) begin
            step(1'b1, 12'($urandom), 2'd1);
            total++;
            if (k < HD && RGB !== bars[k]) begin bad++; $display("FAIL pattern_bars k=%0d got=%h exp=%h", k, RGB, bars[k]); end
            else if (obs !== exp_vec(n)) begin bad++; $display("FAIL pattern_bars_vec n=%0d got=%h exp=%h", n, obs, exp_vec(n)); end
        end
        for (int i = 0; i < 2 * FTOT; i++) begin
            step(1'b1, 12'($urandom), 2'($urandom));
            total++;
            if (obs !== exp_vec(n)) begin
                bad++;
                if (bad < 30) $display("FAIL pattern_mix n=%0d got=%h exp=%h", n, obs, exp_vec(n));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_free_run();
        test_const_rgb();
        test_ce_gating();
        test_async_reset();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
